sys_bus_responder: RTL and testbench

//  Synthesizable target (responder) end of the Red Pitaya system bus. It holds a bank of NREG

---
 rtl/sys_bus_rsp_pkg.sv | 15 +
 rtl/sys_bus_rsp_bytereg.sv | 19 +
 rtl/sys_bus_responder.sv | 132 +++++++++++++
 tb/tb_sys_bus_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_rsp_pkg.sv
// sys_bus_rsp_pkg: shared types and helpers for the system-bus responder
package sys_bus_rsp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int STAT_WR = 0;
  localparam int STAT_RD = 1;
  localparam int STAT_ERR = 2;
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic sel);
    return sel ? new_b : old_b;
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/sys_bus_rsp_bytereg.sv
// sys_bus_rsp_bytereg: one DW-wide register with per-byte write select
module sys_bus_rsp_bytereg
  import sys_bus_rsp_pkg::*;
#(
  parameter int DW = 32,
  parameter int SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW-1:0] sel,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (we)
      for (int i = 0; i < SW; i++) q[8*i +: 8] <= byte_merge(q[8*i +: 8], wdata[8*i +: 8], sel[i]);
endmodule

// File: rtl/sys_bus_responder.sv
// sys_bus_responder: Red Pitaya system-bus responder with NREG byte-writable registers; SYS_BUS_RSP_STATS_EN adds read-only counters
module sys_bus_responder
  import sys_bus_rsp_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int SW   = DW / 8,
  parameter int NREG = 8,
  parameter int LAT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      sys_addr,
  input  logic [DW-1:0]      sys_wdata,
  input  logic [SW-1:0]      sys_sel,
  input  logic               sys_wen,
  input  logic               sys_ren,
  output logic [DW-1:0]      sys_rdata,
  output logic               sys_err,
  output logic               sys_ack,
  output logic [NREG*DW-1:0] reg_o,
  output logic               busy,
  output logic               ovf
);
  localparam int WW = AW - 2;
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WW-1:0] w_q, w;
  logic [DW-1:0] wdata_q, wd, rd_val;
  logic [SW-1:0] sel_q, sl;
  logic we_q, re_q, we, re;
  logic idle, strobe, go, stat_hit, err;
  logic [DW-1:0] q [NREG];
  logic unused_addr;
  assign unused_addr = ^sys_addr[1:0];
  assign idle = state == IDLE;
  assign busy = !idle;
  assign strobe = sys_wen | sys_ren;
  // In IDLE the transaction is taken straight from the bus so LAT=0 can respond on the next cycle
  assign w  = idle ? sys_addr[AW-1:2] : w_q;
  assign wd = idle ? sys_wdata : wdata_q;
  assign sl = idle ? sys_sel : sel_q;
  assign we = idle ? sys_wen : we_q;
  assign re = idle ? sys_ren : re_q;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    go = 1'b0;
    case (state)
      IDLE: if (strobe) begin
        state_nx = LAT == 0 ? RESP : WAIT;
        cnt_nx = CW'(LAT - 1);
        go = LAT == 0;
      end
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        state_nx = cnt == '0 ? RESP : WAIT;
        go = cnt == '0;
      end
      default: state_nx = IDLE;
    endcase
  end
`ifdef SYS_BUS_RSP_STATS_EN
  logic [31:0] cnt_wr, cnt_rd, cnt_err;
  logic [1:0] err_inc;
  assign stat_hit = w >= WW'(NREG) && w < WW'(NREG + 3);
  assign err_inc = {1'b0, go & err} + {1'b0, strobe & ~idle};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_wr <= '0;
      cnt_rd <= '0;
      cnt_err <= '0;
    end else begin
      cnt_wr <= sat_add(cnt_wr, {1'b0, go & ~err & we});
      cnt_rd <= sat_add(cnt_rd, {1'b0, go & ~err & re});
      cnt_err <= sat_add(cnt_err, err_inc);
    end
`else
  assign stat_hit = 1'b0;
`endif
  // Stats words are read-only, so only a read makes them a valid target
  assign err = (we & re) | ~(w < WW'(NREG) | (stat_hit & re));
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NREG; k++) if (w == WW'(k)) rd_val = q[k];
`ifdef SYS_BUS_RSP_STATS_EN
    if (w == WW'(NREG + STAT_WR)) rd_val = DW'(cnt_wr);
    if (w == WW'(NREG + STAT_RD)) rd_val = DW'(cnt_rd);
    if (w == WW'(NREG + STAT_ERR)) rd_val = DW'(cnt_err);
`endif
  end
  for (genvar k = 0; k < NREG; k++) begin : g_reg
    sys_bus_rsp_bytereg #(.DW(DW), .SW(SW)) u_reg (
      .clk(clk),
      .rst(rst),
      .we(go & we & ~re & (w == WW'(k))),
      .sel(sl),
      .wdata(wd),
      .q(q[k])
    );
    assign reg_o[k*DW +: DW] = q[k];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      w_q <= '0;
      wdata_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      sys_ack <= 1'b0;
      sys_err <= 1'b0;
      sys_rdata <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (idle && strobe) begin
        w_q <= sys_addr[AW-1:2];
        wdata_q <= sys_wdata;
        sel_q <= sys_sel;
        we_q <= sys_wen;
        re_q <= sys_ren;
      end
      sys_ack <= go & ~err;
      sys_err <= go & err;
      sys_rdata <= (go & ~err & re) ? rd_val : '0;
      ovf <= ovf | (strobe & ~idle);
    end
endmodule

// File: tb/tb_sys_bus_responder.sv
// tb_sys_bus_responder: table, directed and random checks of two responders (LAT=0 and LAT=3)
module tb_sys_bus_responder;
  localparam int NREG = 8;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  typedef struct {
    logic we, re;
    logic [31:0] a, wd;
    logic [3:0] s;
    logic e_ack, e_err;
    logic [31:0] e_rd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [3:0] sel [2];
  logic wen [2], ren [2], ack [2], err [2], busy [2], ovf [2];
  logic [255:0] rego [2];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_reg [2][NREG];
  longint m_wr [2], m_rd [2], m_err [2];
  vec_t tv [16];
  always #5 clk = ~clk;
  sys_bus_responder #(.NREG(NREG), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .sys_addr(addr[0]), .sys_wdata(wdata[0]), .sys_sel(sel[0]),
    .sys_wen(wen[0]), .sys_ren(ren[0]), .sys_rdata(rdata[0]), .sys_err(err[0]),
    .sys_ack(ack[0]), .reg_o(rego[0]), .busy(busy[0]), .ovf(ovf[0])
  );
  sys_bus_responder #(.NREG(NREG), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .sys_addr(addr[1]), .sys_wdata(wdata[1]), .sys_sel(sel[1]),
    .sys_wen(wen[1]), .sys_ren(ren[1]), .sys_rdata(rdata[1]), .sys_err(err[1]),
    .sys_ack(ack[1]), .reg_o(rego[1]), .busy(busy[1]), .ovf(ovf[1])
  );
  function automatic int lat_of(input int d);
    return d == 1 ? 3 : 0;
  endfunction
  function automatic vec_t mk(input logic we, re, input logic [31:0] a, wd, input logic [3:0] s,
                              input logic ea, ee, input logic [31:0] er);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.wd = wd; v.s = s; v.e_ack = ea; v.e_err = ee; v.e_rd = er;
    return v;
  endfunction
  function automatic logic [31:0] sat(input longint v);
    return v > 64'sd4294967295 ? 32'hFFFF_FFFF : 32'(v);
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NREG; k++) m_reg[d][k] = '0;
      m_wr[d] = 0; m_rd[d] = 0; m_err[d] = 0;
    end
  endtask
  task automatic model(input int d, input logic we, re, input logic [31:0] a, wd, input logic [3:0] s,
                       output logic e_ack, e_err, output logic [31:0] e_rd);
    int w;
    w = int'(a >> 2);
    e_rd = '0;
    e_ack = 1'b0;
    if (we && re) e_ack = 1'b0;
    else if (w < NREG) begin
      e_ack = 1'b1;
      if (we) begin
        for (int b = 0; b < 4; b++) if (s[b]) m_reg[d][w][8*b +: 8] = wd[8*b +: 8];
      end else e_rd = m_reg[d][w];
    end
`ifdef SYS_BUS_RSP_STATS_EN
    else if (w < NREG + 3 && re) begin
      e_ack = 1'b1;
      e_rd = w == NREG ? sat(m_wr[d]) : w == NREG + 1 ? sat(m_rd[d]) : sat(m_err[d]);
    end
`endif
    e_err = !e_ack;
    if (e_ack && we) m_wr[d]++;
    if (e_ack && re) m_rd[d]++;
    if (e_err) m_err[d]++;
  endtask
  function automatic logic [255:0] m_rego(input int d);
    logic [255:0] v;
    for (int k = 0; k < NREG; k++) v[32*k +: 32] = m_reg[d][k];
    return v;
  endfunction
  task automatic txn(input int d, input logic we, re, input logic [31:0] a, wd, input logic [3:0] s,
                     input logic e_ack, e_err, input logic [31:0] e_rd, input string tag);
    int n, busy_n;
    logic got, g_ack, g_err;
    logic [31:0] g_rd;
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; sel[d] = s; wen[d] = we; ren[d] = re;
    got = 1'b0; n = 0; busy_n = 0; g_ack = 1'b0; g_err = 1'b0; g_rd = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin wen[d] = 1'b0; ren[d] = 1'b0; end
      if (busy[d]) busy_n++;
      if (ack[d] || err[d]) begin got = 1'b1; g_ack = ack[d]; g_err = err[d]; g_rd = rdata[d]; end
    end
    chk({tag, " latency"}, got ? n : 0, lat_of(d) + 1);
    chk({tag, " busy cycles"}, busy_n, lat_of(d) + 1);
    chk({tag, " ack/err"}, {g_ack, g_err}, {e_ack, e_err});
    if (!(e_ack && we)) chk({tag, " rdata"}, g_rd, e_rd);
    @(negedge clk);
    chk({tag, " one-cycle pulse"}, {ack[d], err[d], busy[d], rdata[d]}, '0);
  endtask
  task automatic ovf_seq(input int d);
    int acks, errs;
    logic ea, ee;
    logic [31:0] er;
    chk($sformatf("d%0d ovf clear before", d), ovf[d], 1'b0);
    @(negedge clk);
    addr[d] = 32'h0; ren[d] = 1'b1;
    model(d, N, Y, 32'h0, 32'h0, 4'h0, ea, ee, er);
    m_err[d]++;
    acks = 0; errs = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 2) ren[d] = 1'b0;
      if (ack[d]) acks++;
      if (err[d]) errs++;
    end
    chk($sformatf("d%0d ovf ack count", d), acks, 1);
    chk($sformatf("d%0d ovf err count", d), errs, 0);
    chk($sformatf("d%0d ovf sticky", d), ovf[d], 1'b1);
  endtask
  initial begin
    logic ea, ee;
    logic [31:0] er;
    logic [255:0] exp_reg;
    int kind, acks;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; sel[d] = '0; wen[d] = 1'b0; ren[d] = 1'b0;
    end
    m_reset();
    tv[0]  = mk(Y, N, 32'h04, 32'hDEAD_BEEF, 4'hF, Y, N, 32'h0);
    tv[1]  = mk(N, Y, 32'h04, 32'h0, 4'h0, Y, N, 32'hDEAD_BEEF);
    tv[2]  = mk(Y, N, 32'h04, 32'h1122_3344, 4'b0101, Y, N, 32'h0);
    tv[3]  = mk(N, Y, NREG * 4 + 32'h40, 32'h0, 4'h0, N, Y, 32'h0);
`ifdef SYS_BUS_RSP_STATS_EN
    tv[4]  = mk(N, Y, 32'h24, 32'h0, 4'h0, Y, N, 32'd1);
    tv[5]  = mk(N, Y, 32'h20, 32'h0, 4'h0, Y, N, 32'd2);
    tv[6]  = mk(N, Y, 32'h28, 32'h0, 4'h0, Y, N, 32'd1);
`else
    tv[4]  = mk(N, Y, 32'h24, 32'h0, 4'h0, N, Y, 32'h0);
    tv[5]  = mk(N, Y, 32'h20, 32'h0, 4'h0, N, Y, 32'h0);
    tv[6]  = mk(N, Y, 32'h28, 32'h0, 4'h0, N, Y, 32'h0);
`endif
    tv[7]  = mk(N, Y, 32'h04, 32'h0, 4'h0, Y, N, 32'hDE22_BE44);
    tv[8]  = mk(Y, Y, 32'h00, 32'hFFFF_FFFF, 4'hF, N, Y, 32'h0);
    tv[9]  = mk(Y, N, 32'h1F, 32'hCAFE_F00D, 4'hF, Y, N, 32'h0);
    tv[10] = mk(N, Y, 32'h1C, 32'h0, 4'h0, Y, N, 32'hCAFE_F00D);
    tv[11] = mk(Y, N, 32'h20, 32'h1, 4'hF, N, Y, 32'h0);
    tv[12] = mk(N, Y, 32'h00, 32'h0, 4'h0, Y, N, 32'h0);
    tv[13] = mk(Y, N, 32'h2C, 32'h5, 4'hF, N, Y, 32'h0);
    tv[14] = mk(N, Y, 32'h2C, 32'h0, 4'h0, N, Y, 32'h0);
    tv[15] = mk(Y, N, 32'h00, 32'h0000_00A5, 4'b0001, Y, N, 32'h0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d reset outputs", d), {ack[d], err[d], busy[d], ovf[d], rdata[d]}, '0);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d reset regs", d), rego[d], '0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        model(d, tv[i].we, tv[i].re, tv[i].a, tv[i].wd, tv[i].s, ea, ee, er);
        txn(d, tv[i].we, tv[i].re, tv[i].a, tv[i].wd, tv[i].s, tv[i].e_ack, tv[i].e_err, tv[i].e_rd,
            $sformatf("tv%0d d%0d", i, d));
      end
      exp_reg = '0;
      exp_reg[31:0] = 32'h0000_00A5;
      exp_reg[63:32] = 32'hDE22_BE44;
      exp_reg[255:224] = 32'hCAFE_F00D;
      chk($sformatf("d%0d reg_o after table", d), rego[d], exp_reg);
      ovf_seq(d);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 60; i++) begin
        logic we, re;
        logic [31:0] wd;
        logic [3:0] s;
        kind = $urandom_range(0, 9);
        we = kind <= 4;
        re = kind == 0 || kind >= 5;
        a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
        wd = $urandom;
        s = 4'($urandom_range(0, 15));
        model(d, we, re, a, wd, s, ea, ee, er);
        txn(d, we, re, a, wd, s, ea, ee, er, $sformatf("rnd%0d d%0d", i, d));
        chk($sformatf("rnd%0d d%0d reg_o", i, d), rego[d], m_rego(d));
      end
    @(negedge clk);
    addr[1] = 32'h4; ren[1] = 1'b1;
    @(negedge clk);
    ren[1] = 1'b0;
    @(negedge clk);
    chk("mid-wait busy before rst", busy[1], 1'b1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d outputs in rst", d), {ack[d], err[d], busy[d], ovf[d], rdata[d], rego[d]}, '0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack[1] || err[1]) acks++;
    end
    chk("no response after mid-wait rst", acks, 0);
    model(1, N, Y, 32'h4, 32'h0, 4'h0, ea, ee, er);
    txn(1, N, Y, 32'h4, 32'h0, 4'h0, ea, ee, er, "post-rst read");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
